// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Latency: result on HI/LO WIDTH+1 cycles after the start edge; start is ignored while busy.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // operand decode at the start edge
    logic             sgn_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn_op = ~op[0];
    assign a_neg  = sgn_op & A[WIDTH-1];
    assign b_neg  = sgn_op & B[WIDTH-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;

    // one shift-add multiply step: {acc,wrk} holds the partial product and the multiplier
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_wrk;

    assign mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc = mul_sum[WIDTH:1];
    assign mul_wrk = {mul_sum[0], wrk_q[WIDTH-1:1]};

    // one restoring divide step: acc is the partial remainder, wrk shifts dividend out / quotient in
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc, div_wrk;

    assign div_sh   = {acc_q, wrk_q[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    assign div_ge   = ~div_diff[WIDTH+1];
    assign div_acc  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_wrk  = {wrk_q[WIDTH-2:0], div_ge};

    // sign correction applied only in FIN
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_raw = {acc_q, wrk_q};
    assign prod_fix = res_neg_q ? -prod_raw : prod_raw;
    assign quo_fix  = div0_q ? '1 : (res_neg_q ? -wrk_q : wrk_q);
    assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = CW'(WIDTH);
                    is_div_d  = op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    div0_d    = op[1] & (B == '0);
                    opnd_d    = op[1] ? b_mag : a_mag;
                    acc_d     = '0;
                    wrk_d     = op[1] ? a_mag : b_mag;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_acc : mul_acc;
                wrk_d = is_div_q ? div_wrk : mul_wrk;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed HI/LO, latency, handshake and MTHI/MTLO cases.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive a request, let the start edge take it, then scramble operands
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // mode 1: pulse an ignored start mid-op; mode 2: MTHI strobe mid-op
    task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int mode, input logic [31:0] hi_prev);
        int lat;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (mode == 1 && n == 5) begin
                op = DIVU; A = 32'd9; B = 32'd3; start = 1'b1;
            end
            if (mode == 1 && n == 6) start = 1'b0;
            if (mode == 2 && n == 3) begin
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (mode == 2 && n == 4) begin
                hi_we = 1'b0;
                chk({tag, "_hi_busy_write"}, HI, hi_prev);
            end
        end
        chk({tag, "_latency"}, lat, 32'd33);
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        chk({tag, "_HI"}, HI, exp_hi);
        chk({tag, "_LO"}, LO, exp_lo);
    endtask

    task automatic done_gone(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(o, a, b);
        wait_done(tag, exp_hi, exp_lo, 0, 32'd0);
        done_gone(tag);
    endtask

    task automatic no_done_window(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk({tag, "_no_done"}, seen, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MTHI+MTLO together while idle
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_we_HI", HI, 32'hA5A5A5A5);
        chk("both_we_LO", LO, 32'hA5A5A5A5);

        // reset in the middle of a MULTU aborts without done
        start_op(MULTU, 32'h00010000, 32'h00010000);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        no_done_window("abort");
        @(negedge clk);

        run("mult_2x3", MULT, 32'd2, 32'd3, 32'd0, 32'd6);
        run("mult_m3x5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // an extra start while busy must neither disturb nor queue
        start_op(DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", 32'd2, 32'd14, 1, 32'd0);
        done_gone("divu_100_7");
        no_done_window("ignored_start");

        run("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run("divu_by0", DIVU, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF);
        run("div_neg_by0", DIV, 32'hFFFFFB2E, 32'd0, 32'hFFFFFB2E, 32'hFFFFFFFF);

        // back-to-back: second start issued in the done cycle
        start_op(MULT, 32'd2, 32'd3);
        wait_done("b2b_first", 32'd0, 32'd6, 0, 32'd0);
        start_op(DIV, 32'd7, 32'hFFFFFFFE);
        chk("b2b_done_dropped", {31'b0, done}, 32'd0);
        wait_done("b2b_second", 32'd1, 32'hFFFFFFFD, 0, 32'd0);
        done_gone("b2b_second");

        // MTHI ignored while busy, honoured in the cycle after done
        start_op(MULTU, 32'h00030000, 32'h00010000);
        wait_done("multu_hiwe", 32'd3, 32'd0, 2, 32'd1);
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("idle_hi_we_HI", HI, 32'hDEADBEEF);
        chk("idle_hi_we_LO", LO, 32'd0);
        chk("idle_hi_we_done", {31'b0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
